// File: rtl/serial_pattern_if.sv
// serial_pattern_if: request/status bundle between a pattern requester and serial_pattern_tx
interface serial_pattern_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             start;
  logic             use_def;
  logic [WIDTH-1:0] pattern;
  logic [CNT_W-1:0] reps;
  logic             out;
  logic             out_valid;
  logic             busy;
  logic             done;
  modport master (output start, use_def, pattern, reps, input out, out_valid, busy, done);
  modport slave  (input start, use_def, pattern, reps, output out, out_valid, busy, done);
endinterface

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: shifts a captured pattern out MSB-first for a programmable number of repetitions
// Optional inter-repetition idle gap built when SERIAL_PATTERN_GAP_EN is defined.
module serial_pattern_tx #(
  parameter int               WIDTH       = 4,
  parameter int               CNT_W       = 8,
  parameter int               GAP_LEN     = 2,
  parameter logic [WIDTH-1:0] DEF_PATTERN = 4'b1010
) (
  input logic              clk,
  input logic              rst_n,
  serial_pattern_if.slave  bus
);
  localparam int BW = $clog2(WIDTH);
  if (WIDTH < 2 || GAP_LEN < 1) begin : g_param_check
    $error("serial_pattern_tx: WIDTH must be >= 2 and GAP_LEN >= 1");
  end
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_hold;
  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_rep;
  logic [BW-1:0]    r_bit;
  logic             r_out;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] w_sel;
  logic [CNT_W-1:0] w_reps;
  logic             w_last;
  logic             w_more;
`ifdef SERIAL_PATTERN_GAP_EN
  localparam int GW = GAP_LEN > 1 ? $clog2(GAP_LEN) : 1;
  logic [GW-1:0] r_gap;
`endif
  assign w_sel  = bus.use_def ? DEF_PATTERN : bus.pattern;
  assign w_reps = bus.reps == '0 ? CNT_W'(1) : bus.reps;
  assign w_last = r_bit == BW'(WIDTH - 1);
  assign w_more = r_rep > CNT_W'(1);
  // r_out always mirrors the bit the shift register presents in the current cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_shift <= '0;
      r_rep   <= '0;
      r_bit   <= '0;
      r_out   <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SERIAL_PATTERN_GAP_EN
      r_gap   <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) begin
          r_state <= SHIFT;
          r_hold  <= w_sel;
          r_shift <= w_sel;
          r_rep   <= w_reps;
          r_bit   <= '0;
          r_out   <= w_sel[WIDTH-1];
          r_valid <= 1'b1;
          r_busy  <= 1'b1;
        end
        SHIFT: if (!w_last) begin
          r_shift <= r_shift << 1;
          r_out   <= r_shift[WIDTH-2];
          r_bit   <= r_bit + BW'(1);
        end else if (w_more) begin
          r_rep   <= r_rep - CNT_W'(1);
          r_bit   <= '0;
          r_shift <= r_hold;
`ifdef SERIAL_PATTERN_GAP_EN
          r_state <= GAP;
          r_gap   <= '0;
          r_out   <= 1'b0;
          r_valid <= 1'b0;
`else
          r_out   <= r_hold[WIDTH-1];
`endif
        end else begin
          r_state <= IDLE;
          r_bit   <= '0;
          r_out   <= 1'b0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
`ifdef SERIAL_PATTERN_GAP_EN
        GAP: if (r_gap == GW'(GAP_LEN - 1)) begin
          r_state <= SHIFT;
          r_out   <= r_hold[WIDTH-1];
          r_valid <= 1'b1;
        end else begin
          r_gap <= r_gap + GW'(1);
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.out       = r_out;
  assign bus.out_valid = r_valid;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: per-cycle comparison against a queue-based stream model plus directed literal checks
module tb_serial_pattern_tx;
  localparam int W  = 4;
  localparam int CW = 8;
  localparam int GL = 2;
`ifdef SERIAL_PATTERN_GAP_EN
  localparam int GAP_ON = 1;
`else
  localparam int GAP_ON = 0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  serial_pattern_if #(.WIDTH(W), .CNT_W(CW)) bus ();
  serial_pattern_tx #(.WIDTH(W), .CNT_W(CW), .GAP_LEN(GL), .DEF_PATTERN(4'b1010)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct packed {logic out; logic valid; logic busy; logic done;} obs_t;
  obs_t q[$];
  obs_t cur = '0;
  int checks = 0;
  int errors = 0;
  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction
  // Expected per-cycle stream of one whole transfer, ending with the done cycle
  function automatic void build(logic ud, logic [W-1:0] p, logic [CW-1:0] r);
    int reps_eff = (r == 0) ? 1 : int'(r);
    logic [W-1:0] s = ud ? 4'b1010 : p;
    for (int k = 0; k < reps_eff; k++) begin
      for (int i = W - 1; i >= 0; i--) q.push_back('{s[i], 1'b1, 1'b1, 1'b0});
      if (GAP_ON != 0 && k < reps_eff - 1)
        for (int g = 0; g < GL; g++) q.push_back('{1'b0, 1'b0, 1'b1, 1'b0});
    end
    q.push_back('{1'b0, 1'b0, 1'b0, 1'b1});
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      cur <= '0;
    end else begin
      if (q.size() == 0 && bus.start) build(bus.use_def, bus.pattern, bus.reps);
      if (q.size() != 0) cur <= q.pop_front();
      else cur <= '0;
    end
  end
  always @(negedge clk) begin
    chk("obs{out,valid,busy,done}", {bus.out, bus.out_valid, bus.busy, bus.done}, cur);
    chk("done_and_valid", bus.done & bus.out_valid, 0);
  end
  task automatic xfer(input logic now, input logic ud, input logic [W-1:0] p, input logic [CW-1:0] r,
                      input int poke, output logic [63:0] bits, output int nb, output int de);
    bits = '0;
    nb = 0;
    de = -1;
    if (!now) @(negedge clk);
    bus.start = 1'b1;
    bus.use_def = ud;
    bus.pattern = p;
    bus.reps = r;
    for (int e = 1; e <= 2000; e++) begin
      @(negedge clk);
      bus.start = (e == poke);
      if (e == poke) begin
        bus.pattern = ~p;
        bus.use_def = ~ud;
        bus.reps = r + 8'd3;
      end
      if (bus.out_valid) begin
        bits = {bits[62:0], bus.out};
        nb++;
      end
      if (bus.done) begin
        de = e;
        break;
      end
    end
    bus.start = 1'b0;
  endtask
  logic [63:0] bits;
  int nb, de, sp;
  initial begin
    bus.start = 1'b1;
    bus.use_def = 1'b0;
    bus.pattern = 4'b1111;
    bus.reps = 8'd2;
    #1 rst_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_outputs", {bus.out, bus.out_valid, bus.busy, bus.done}, 0);
    rst_n = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_start_after_reset", bus.busy, 0);
    xfer(0, 1'b1, 4'b0000, 8'd1, 0, bits, nb, de);
    chk("def_bits", bits[3:0], 4'b1010);
    chk("def_nbits", nb, 4);
    chk("def_done_edge", de, 5);
    xfer(0, 1'b0, 4'b1100, 8'd3, 0, bits, nb, de);
    chk("rep3_bits", bits[11:0], 12'b110011001100);
    chk("rep3_nbits", nb, 12);
    chk("rep3_done_edge", de, GAP_ON != 0 ? 17 : 13);
    xfer(0, 1'b0, 4'b0110, 8'd0, 2, bits, nb, de);
    chk("reps0_poke_bits", bits[3:0], 4'b0110);
    chk("reps0_poke_nbits", nb, 4);
    chk("reps0_poke_done_edge", de, 5);
    xfer(0, 1'b0, 4'b1001, 8'd1, 0, bits, nb, de);
    chk("b2b_first_done_edge", de, 5);
    xfer(1, 1'b1, 4'b0000, 8'd2, 0, bits, nb, de);
    chk("b2b_bits", bits[7:0], 8'b10101010);
    chk("b2b_done_edge", de, GAP_ON != 0 ? 11 : 9);
    @(negedge clk);
    bus.start = 1'b1;
    bus.pattern = 4'b1111;
    bus.use_def = 1'b0;
    bus.reps = 8'd2;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk("async_reset_outputs", {bus.out, bus.out_valid, bus.busy, bus.done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sp = 0;
    repeat (8) begin
      @(negedge clk);
      sp += bus.done + bus.busy;
    end
    chk("no_done_after_abort", sp, 0);
    xfer(0, 1'b0, 4'b1011, 8'd1, 0, bits, nb, de);
    chk("post_reset_bits", bits[3:0], 4'b1011);
    chk("post_reset_done_edge", de, 5);
    xfer(0, 1'b1, 4'b0000, 8'd255, 0, bits, nb, de);
    chk("reps255_nbits", nb, 1020);
    chk("reps255_done_edge", de, GAP_ON != 0 ? 1529 : 1021);
    repeat (4000) begin
      @(negedge clk);
      bus.start = $urandom_range(0, 3) == 0;
      bus.use_def = 1'($urandom_range(0, 1));
      bus.pattern = W'($urandom);
      bus.reps = ($urandom_range(0, 99) == 0) ? CW'($urandom_range(0, 255)) : CW'($urandom_range(0, 5));
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    bus.start = 1'b0;
    repeat (1600) @(negedge clk);
    chk("model_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
